// File: rtl/avr_prefetch_unit.sv
// avr_prefetch_unit: DEPTH-word instruction prefetch queue between the synchronous program ROM and decode.
// Define AVR_PREFETCH_LONG_EN to present 32-bit JMP/CALL/LDS/STS as one two-word instruction.
module avr_prefetch_unit #(
  parameter int PC_W       = 16,
  parameter int DEPTH      = 4,
  parameter int SWAP_BYTES = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2:0]      pc_src,
  input  logic [PC_W-1:0] jmp,
  output logic            prog_req,
  output logic [PC_W-1:0] prog_addr,
  input  logic [15:0]     prog_data,
  output logic            instr_valid,
  output logic [15:0]     cur_instr,
  output logic [15:0]     cur_ext,
  output logic [1:0]      instr_len,
  output logic [PC_W-1:0] cur_pc,
  output logic [PC_W-1:0] ret_pc
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  localparam logic [2:0] SRC_RESTART = 3'b000;
  localparam logic [2:0] SRC_ADVANCE = 3'b010;
  localparam logic [2:0] SRC_REL     = 3'b100;
  localparam logic [2:0] SRC_ABS     = 3'b101;

  function automatic logic [15:0] swap_word(input logic [15:0] w);
    return (SWAP_BYTES != 0) ? {w[7:0], w[15:8]} : w;
  endfunction

`ifdef AVR_PREFETCH_LONG_EN
  function automatic logic is_long(input logic [15:0] w);
    return ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11)) ||
           ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000));
  endfunction
`endif

  logic [15:0]      word_q [DEPTH];
  logic [PC_W-1:0]  addr_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  fetch_pc;
  logic             vld_p1;
  logic [PC_W-1:0]  addr_p1;

  logic [15:0]            head_word;
  logic [15:0]            ext_word;
  logic                   head_long;
  logic                   redirect;
  logic                   push;
  logic [1:0]             pop_words;
  logic [OCC_W-1:0]       occ_after;
  logic signed [PC_W-1:0] rel_off;
  logic [PC_W-1:0]        target;

  assign head_word = word_q[rd_ptr];
`ifdef AVR_PREFETCH_LONG_EN
  assign head_long = is_long(head_word);
  assign ext_word  = word_q[rd_ptr + PTR_W'(1)];
`else
  assign head_long = 1'b0;
  assign ext_word  = 16'h0000;
`endif

  always_comb begin
    instr_valid = (count != '0) && (!head_long || (count >= CNT_W'(2)));
    instr_len   = instr_valid ? (head_long ? 2'd2 : 2'd1) : 2'd0;
    cur_instr   = instr_valid ? head_word : 16'h0000;
    cur_ext     = (instr_valid && head_long) ? ext_word : 16'h0000;
    // With nothing queued, the head is whatever word arrives next.
    if (count != '0)  cur_pc = addr_q[rd_ptr];
    else if (vld_p1)  cur_pc = addr_p1;
    else              cur_pc = fetch_pc;
    ret_pc    = cur_pc + PC_W'(instr_len);
    redirect  = (pc_src == SRC_RESTART) || (pc_src == SRC_REL) || (pc_src == SRC_ABS);
    pop_words = (pc_src == SRC_ADVANCE) ? instr_len : 2'd0;
    occ_after = OCC_W'(count) - OCC_W'(pop_words) + OCC_W'(vld_p1);
    prog_req  = !RST && !redirect && (occ_after < OCC_W'(DEPTH));
    prog_addr = fetch_pc;
    push      = vld_p1 && !redirect;
    rel_off   = $signed(jmp);
    case (pc_src)
      SRC_REL: target = cur_pc + PC_W'(1) + $unsigned(rel_off);
      SRC_ABS: target = jmp;
      default: target = '0;
    endcase
  end

  // Issue stage: queue control, fetch pointer and in-flight tracking.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= '0;
      vld_p1   <= 1'b0;
    end else if (redirect) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      fetch_pc <= target;
      vld_p1   <= 1'b0;
    end else begin
      if (prog_req) fetch_pc <= fetch_pc + PC_W'(1);
      vld_p1 <= prog_req;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr <= rd_ptr + PTR_W'(pop_words);
      count  <= count + CNT_W'(push) - CNT_W'(pop_words);
    end
  end

  // Return stage: the word requested last cycle lands in the queue with its address.
  always_ff @(posedge CLK) begin
    if (prog_req) addr_p1 <= fetch_pc;
    if (push) begin
      word_q[wr_ptr] <= swap_word(prog_data);
      addr_q[wr_ptr] <= addr_p1;
    end
  end

endmodule

// File: tb/tb_avr_prefetch_unit.sv
// Scoreboard bench for avr_prefetch_unit: instruction-stream reference model plus directed scenarios.
module tb_avr_prefetch_unit;
  localparam int PC_W = 16;
  localparam int DEPTH = 4;
  localparam int SWAP = 1;
`ifdef AVR_PREFETCH_LONG_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif
  localparam logic [2:0] SRC_RESTART = 3'b000;
  localparam logic [2:0] SRC_HOLD    = 3'b001;
  localparam logic [2:0] SRC_ADV     = 3'b010;
  localparam logic [2:0] SRC_REL     = 3'b100;
  localparam logic [2:0] SRC_ABS     = 3'b101;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [2:0]      pc_src = SRC_HOLD;
  logic [PC_W-1:0] jmp = '0;
  logic            prog_req;
  logic [PC_W-1:0] prog_addr;
  logic [15:0]     prog_data;
  logic            instr_valid;
  logic [15:0]     cur_instr;
  logic [15:0]     cur_ext;
  logic [1:0]      instr_len;
  logic [PC_W-1:0] cur_pc;
  logic [PC_W-1:0] ret_pc;

  avr_prefetch_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .SWAP_BYTES(SWAP)) dut (
    .CLK(CLK), .RST(RST), .pc_src(pc_src), .jmp(jmp),
    .prog_req(prog_req), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_valid(instr_valid), .cur_instr(cur_instr), .cur_ext(cur_ext),
    .instr_len(instr_len), .cur_pc(cur_pc), .ret_pc(ret_pc)
  );

  always #5 CLK = ~CLK;

  logic [15:0] rom [65536];
  always @(posedge CLK) prog_data <= prog_req ? rom[prog_addr] : 16'($urandom);

  typedef struct {
    logic [PC_W-1:0] pc;
    logic [15:0]     instr;
    logic [15:0]     ext;
    logic [1:0]      len;
    logic [PC_W-1:0] ret;
  } exp_t;

  exp_t            exp_q[$];
  logic [PC_W-1:0] tail_pc = '0;
  bit              pend = 1'b0;
  logic [PC_W-1:0] pend_tgt = '0;
  bit              mon_en = 1'b0;
  int              since = 0;
  int              streak = 0;
  int              n_tests = 0;
  int              n_fail = 0;

  function automatic logic [15:0] sw(input logic [15:0] w);
    return (SWAP != 0) ? {w[7:0], w[15:8]} : w;
  endfunction

  function automatic logic long_op(input logic [15:0] w);
    if (!LONG_EN) return 1'b0;
    return ((w[15:9] == 7'b1001010) && (w[3:2] == 2'b11)) ||
           ((w[15:10] == 6'b100100) && (w[3:0] == 4'b0000));
  endfunction

  function automatic exp_t mk(input logic [PC_W-1:0] pc);
    exp_t e;
    logic [PC_W-1:0] nx;
    nx      = pc + 1'b1;
    e.pc    = pc;
    e.instr = sw(rom[pc]);
    e.len   = long_op(e.instr) ? 2'd2 : 2'd1;
    e.ext   = (e.len == 2'd2) ? sw(rom[nx]) : 16'h0000;
    e.ret   = pc + PC_W'(e.len);
    return e;
  endfunction

  task automatic refill();
    exp_t e;
    while (exp_q.size() < 8) begin
      e = mk(tail_pc);
      exp_q.push_back(e);
      tail_pc = tail_pc + PC_W'(e.len);
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus; a redirect reshapes the expected stream from the next cycle on.
  task automatic step(input logic r, input logic [2:0] s, input logic [PC_W-1:0] j);
    @(posedge CLK);
    #1;
    if (pend) begin
      exp_q.delete();
      tail_pc = pend_tgt;
      pend = 1'b0;
    end
    refill();
    RST = r; pc_src = s; jmp = j;
    if (r) begin
      pend = 1'b1; pend_tgt = '0;
    end else begin
      case (s)
        SRC_RESTART: begin pend = 1'b1; pend_tgt = '0; end
        SRC_REL:     begin pend = 1'b1; pend_tgt = exp_q[0].pc + 1'b1 + j; end
        SRC_ABS:     begin pend = 1'b1; pend_tgt = j; end
        default:     ;
      endcase
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] s, input logic [PC_W-1:0] j);
    step(r, s, j);
    @(negedge CLK);
  endtask

  initial begin : monitor
    exp_t h;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (since < 1000) since++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL model_empty: got 0 entries expected >0");
        end else begin
          h = exp_q[0];
          chk("cur_pc", cur_pc, h.pc);
          if (RST) chk("req_in_reset", prog_req, 0);
          if (since <= int'(h.len) + 2)
            chk("first_valid_time", instr_valid, since == int'(h.len) + 2);
          if (instr_valid) begin
            chk("cur_instr", cur_instr, h.instr);
            chk("cur_ext", cur_ext, h.ext);
            chk("instr_len", instr_len, h.len);
            chk("ret_pc", ret_pc, h.ret);
            streak = 0;
            if (pc_src == SRC_ADV && !RST) void'(exp_q.pop_front());
          end else begin
            chk("idle_outputs", {cur_instr, cur_ext, instr_len, ret_pc}, {32'h0, 2'b00, h.pc});
            if (since > 6) begin
              streak++;
              chk("stall_bound", streak <= 4, 1);
            end
          end
        end
        if (RST || pc_src == SRC_RESTART || pc_src == SRC_REL || pc_src == SRC_ABS) since = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [15:0] w;
    int pulses, r;
    logic [2:0] s;
    logic [PC_W-1:0] j;
    for (int i = 0; i < 65536; i++) begin
      w = 16'($urandom);
      case ($urandom_range(0, 7))
        0: w = 16'h940C | (w & 16'h01F3);
        1: w = 16'h9000 | (w & 16'h03F0);
        default: ;
      endcase
      rom[i] = sw(w);
    end
    for (int i = 0; i < 64; i++) rom[i] = sw(16'(i));
    rom[16'h0100] = sw(16'h940C);
    rom[16'h0101] = sw(16'h0123);
    for (int i = 0; i < 14; i++) rom[16'h0102 + i] = sw(16'(i));
    rom[16'hFFFF] = sw(16'h0005);

    // Reset state
    @(posedge CLK);
    #1;
    exp_q.delete(); tail_pc = '0; refill();
    since = 0; mon_en = 1'b1;
    @(negedge CLK);
    chk("rst_prog_req", prog_req, 0);
    chk("rst_prog_addr", prog_addr, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_outputs", {cur_instr, cur_ext, instr_len, cur_pc, ret_pc}, 0);

    // Sequential advance from 0
    cyc(0, SRC_ADV, '0);
    cyc(0, SRC_ADV, '0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, SRC_ADV, '0);
      chk("seq_valid", instr_valid, 1);
      chk("seq_instr", cur_instr, i);
      chk("seq_pc", cur_pc, i);
    end

    // 32-bit JMP at 0x100
    cyc(0, SRC_ABS, 16'h0100);
    cyc(0, SRC_HOLD, '0);
    cyc(0, SRC_HOLD, '0);
    cyc(0, SRC_HOLD, '0);
    chk("jmp_valid_t3", instr_valid, !LONG_EN);
    cyc(0, SRC_HOLD, '0);
    chk("jmp_valid_t4", instr_valid, 1);
    chk("jmp_instr", cur_instr, 16'h940C);
    chk("jmp_ext", cur_ext, LONG_EN ? 16'h0123 : 16'h0000);
    chk("jmp_len", instr_len, LONG_EN ? 2 : 1);
    chk("jmp_ret", ret_pc, LONG_EN ? 16'h0102 : 16'h0101);
    cyc(0, SRC_ADV, '0);
    cyc(0, SRC_ADV, '0);

    // Relative redirect backwards with a word in flight
    cyc(0, SRC_ABS, 16'h0010);
    cyc(0, SRC_HOLD, '0);
    cyc(0, SRC_HOLD, '0);
    cyc(0, SRC_REL, 16'hFFFE);
    chk("rel_src_pc", cur_pc, 16'h0010);
    cyc(0, SRC_HOLD, '0);
    chk("rel_req", prog_req, 1);
    chk("rel_fetch_addr", prog_addr, 16'h000F);
    cyc(0, SRC_HOLD, '0);
    cyc(0, SRC_HOLD, '0);
    chk("rel_pc", cur_pc, 16'h000F);
    chk("rel_instr", {instr_valid, cur_instr}, {1'b1, 16'h000F});

    // Absolute redirect to the top of memory, then wrap
    cyc(0, SRC_ABS, 16'hFFFF);
    cyc(0, SRC_ADV, '0);
    cyc(0, SRC_ADV, '0);
    cyc(0, SRC_ADV, '0);
    chk("wrap_pc_top", {instr_valid, cur_pc}, {1'b1, 16'hFFFF});
    cyc(0, SRC_ADV, '0);
    chk("wrap_pc_zero", {instr_valid, cur_pc}, {1'b1, 16'h0000});

    // Hold fills exactly DEPTH words, release streams without bubbles
    cyc(0, SRC_ABS, 16'h0020);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(0, SRC_HOLD, '0);
      if (prog_req) pulses++;
    end
    chk("hold_req_pulses", pulses, DEPTH);
    for (int i = 0; i < 8; i++) begin
      cyc(0, SRC_ADV, '0);
      chk("release_valid", instr_valid, 1);
      chk("release_instr", cur_instr, 16'h0020 + i);
    end
    chk("pre_rst_req", prog_req, 1);

    // Reset while a word is in flight
    cyc(1, SRC_ADV, '0);
    cyc(0, SRC_ADV, '0);
    chk("rst_inflight_valid", instr_valid, 0);
    chk("rst_inflight_pc", cur_pc, 0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      j = 16'($urandom);
      if (r < 2)        cyc(1, 3'($urandom), j);
      else if (r < 62)  cyc(0, SRC_ADV, j);
      else if (r < 76)  cyc(0, SRC_HOLD, j);
      else if (r < 80) begin
        case ($urandom_range(0, 2))
          0: s = 3'b011;
          1: s = 3'b110;
          default: s = 3'b111;
        endcase
        cyc(0, s, j);
      end
      else if (r < 83)  cyc(0, SRC_RESTART, j);
      else if (r < 91)  cyc(0, SRC_REL, 16'($urandom_range(0, 64)) - 16'd32);
      else if (r < 97)  cyc(0, SRC_ABS, j);
      else              cyc(0, SRC_ADV, j);
    end
    cyc(0, SRC_HOLD, '0);
    cyc(0, SRC_HOLD, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
